calendar_date_counter: RTL and testbench
========================================

Name: calendar_date_counter

Overview:
- Parametrised day/month/year/weekday counter for the century clock. Replaces the standalone day counter.
- Advances on the hour-carry pulse in run mode. Edits one field at a time on tick pulses in set mode.
- Keeps day-of-month legal for the current month and leap-year rule at all times.
- Emits single-cycle carry pulses for day, month and year (century) rollover to downstream display and alarm logic.

Parameters:
- YEAR_W, 7, width of the year offset output.
- YEAR_MAX, 99, last legal year offset; the year field wraps YEAR_MAX→0. Must be < 2^YEAR_W.
- CENTURY_BASE, 2000, absolute year represented by year offset 0. Must be a multiple of 400 when LEAP_MODE=1.
- LEAP_MODE, 1, 0 = leap when year[1:0]==0; 1 = full Gregorian on (CENTURY_BASE+year): divisible by 4 and (not by 100, or by 400).
- WEEKDAY_RST, 6, weekday loaded on reset (0=Sunday..6=Saturday; 2000-01-01 is Saturday).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- display  in  1  0 = run mode, 1 = set mode
- set_sel  in  2  set-mode field select: 00 day, 01 month, 10 year, 11 weekday
- tick  in  1  single-cycle edit strobe, set mode only
- inc_dec  in  1  1 = increment, 0 = decrement the selected field
- done_hour  in  1  single-cycle hour-rollover carry, run mode only
- day  out  6  day of month, 1..31
- month  out  4  month, 1..12
- year  out  YEAR_W  year offset, 0..YEAR_MAX
- weekday  out  3  0..6
- done_day  out  1  day-rollover pulse
- done_month  out  1  month-rollover pulse
- done_year  out  1  century-rollover pulse

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: day=1, month=1, year=0, weekday=WEEKDAY_RST, all done_* = 0. Reset overrides every other input, including mid-edit and mid-carry.
- dim (days in month) is combinational from month/year:
  - months 1,3,5,7,8,10,12 → 31
  - months 4,6,9,11 → 30
  - month 2 → 29 if leap, else 28
  - Leap rule is selected by LEAP_MODE; the absolute year is computed at YEAR_W+12 bits to avoid overflow.
- Run mode (display=0), on an edge with done_hour=1:
  - weekday ← (weekday==6) ? 0 : weekday+1.
  - If day<dim: day+1. No carries.
  - Else day←1 and done_day=1. Then:
    - If month<12: month+1.
    - Else month←1 and done_month=1. Then year ← (year==YEAR_MAX) ? 0 : year+1; done_year=1 only on the wrap to 0.
  - Carries cascade in the same edge, so all updated fields become visible together on the next cycle.
  - tick is ignored in run mode.
- Set mode (display=1):
  - done_hour is ignored and the carry is dropped, not queued.
  - On an edge with tick=1, the field selected by set_sel steps by one with wrap:
    - day: 1..dim (inc dim→1, dec 1→dim)
    - month: 1..12
    - year: 0..YEAR_MAX
    - weekday: 0..6
  - No done_* pulse is generated in set mode.
- Clamp: whenever month or year changes (either mode) and the current day > new dim, day ← new dim on the same edge. Example: Jan 31 with month incremented becomes Feb 28 or Feb 29.
- done_day, done_month, done_year:
  - Each is high for exactly the one cycle following the edge that performed the rollover, coincident with the new field values.
  - Each clears on the next edge unless re-triggered.
- Mode change takes effect on the edge at which display is sampled. A done_hour arriving on the same edge as display rising is processed under set mode, i.e. dropped.
- A tick arriving on the same edge as a set_sel change acts on the newly sampled set_sel.
- Illegal states (e.g. month=0) cannot be entered. If forced, the next run-mode increment or set-mode edit must restore a legal value through the wrap rules.

Test Plan:
- Leap year, LEAP_MODE=1, default params: set year=0 (2000), month=2, day=28; pulse done_hour twice → day 29, then Mar 1 with done_day=1 for one cycle and done_month=0.
- Century rule: YEAR_W=8, YEAR_MAX=199, set year=100 (2100), Feb 28; one done_hour → Mar 1 in LEAP_MODE=1, Feb 29 in LEAP_MODE=0.
- Century wrap: default params, year 99, Dec 31; one done_hour → year 0, month 1, day 1, with done_day, done_month and done_year all high the same single cycle.
- Clamp: set mode, Jan 31 year 1; tick inc on month → Feb 28. Repeat with year 4 → Feb 29. Decrement day from 1 in April → 30.
- Set-mode isolation: display=1, done_hour pulsed at Dec 31 → no field change and no done_* pulse. Weekday decrement from 0 → 6.
- Reset mid-operation: assert rst on the same edge as done_hour at Dec 31 year 99 → day=1, month=1, year=0, weekday=6, all done_* = 0 the next cycle.

Source files
------------

// File: rtl/calendar_date_counter_if.sv
// Control and date-field bundle for the calendar date counter.
// The master side drives mode/edit/carry inputs; the slave (counter) returns fields and carries.
interface calendar_date_counter_if #(
   parameter int YEAR_W = 7
);
   logic              display;
   logic [1:0]        set_sel;
   logic              tick;
   logic              inc_dec;
   logic              done_hour;
   logic [5:0]        day;
   logic [3:0]        month;
   logic [YEAR_W-1:0] year;
   logic [2:0]        weekday;
   logic              done_day;
   logic              done_month;
   logic              done_year;

   modport master (
      output display, set_sel, tick, inc_dec, done_hour,
      input  day, month, year, weekday, done_day, done_month, done_year
   );

   modport slave (
      input  display, set_sel, tick, inc_dec, done_hour,
      output day, month, year, weekday, done_day, done_month, done_year
   );
endinterface

// File: rtl/calendar_date_counter.sv
// Day/month/year/weekday counter. Advances on the hour carry in run mode,
// edits one field per tick in set mode, and keeps day-of-month legal at all times.
module calendar_date_counter #(
   parameter int YEAR_W       = 7,
   parameter int YEAR_MAX     = 99,
   parameter int CENTURY_BASE = 2000,
   parameter int LEAP_MODE    = 1,
   parameter int WEEKDAY_RST  = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   calendar_date_counter_if.slave   cal
);

   localparam int AW = YEAR_W + 12;
   localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

   logic [5:0]        day_q, day_d;
   logic [3:0]        month_q, month_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [2:0]        weekday_q, weekday_d;
   logic              done_day_q, done_day_d;
   logic              done_month_q, done_month_d;
   logic              done_year_q, done_year_d;
   logic [5:0]        dim_cur, dim_new;

   // Absolute year is widened so CENTURY_BASE + offset never overflows.
   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      logic [AW-1:0] a;
      a = AW'(CENTURY_BASE) + AW'(y);
      if (LEAP_MODE == 0) return (y[1:0] == 2'd0);
      return (a[1:0] == 2'd0) &&
             (((a % AW'(100)) != '0) || ((a % AW'(400)) == '0));
   endfunction

   // Out-of-range months fall to 31 so a forced illegal month still steps cleanly.
   function automatic logic [5:0] dim_of(input logic [3:0] m, input logic [YEAR_W-1:0] y);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: return 6'd30;
         4'd2:                    return is_leap(y) ? 6'd29 : 6'd28;
         default:                 return 6'd31;
      endcase
   endfunction

   // Next-state: run-mode cascade, set-mode single-field edit, then clamp day to the new month length.
   always_comb begin
      day_d        = day_q;
      month_d      = month_q;
      year_d       = year_q;
      weekday_d    = weekday_q;
      done_day_d   = 1'b0;
      done_month_d = 1'b0;
      done_year_d  = 1'b0;
      dim_cur      = dim_of(month_q, year_q);
      dim_new      = dim_cur;

      if (!cal.display) begin
         if (cal.done_hour) begin
            weekday_d = (weekday_q >= 3'd6) ? 3'd0 : weekday_q + 3'd1;
            if (day_q < dim_cur) begin
               day_d = day_q + 6'd1;
            end else begin
               day_d      = 6'd1;
               done_day_d = 1'b1;
               if (month_q < 4'd12) begin
                  month_d = month_q + 4'd1;
               end else begin
                  month_d      = 4'd1;
                  done_month_d = 1'b1;
                  if (year_q >= YMAX) begin
                     year_d      = '0;
                     done_year_d = 1'b1;
                  end else begin
                     year_d = year_q + 1'b1;
                  end
               end
            end
         end
      end else if (cal.tick) begin
         case (cal.set_sel)
            2'b00: if (cal.inc_dec) day_d = (day_q >= dim_cur) ? 6'd1 : day_q + 6'd1;
                   else             day_d = (day_q <= 6'd1 || day_q > dim_cur) ? dim_cur : day_q - 6'd1;
            2'b01: if (cal.inc_dec) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                   else             month_d = (month_q <= 4'd1 || month_q > 4'd12) ? 4'd12 : month_q - 4'd1;
            2'b10: if (cal.inc_dec) year_d = (year_q >= YMAX) ? '0 : year_q + 1'b1;
                   else             year_d = (year_q == '0 || year_q > YMAX) ? YMAX : year_q - 1'b1;
            default: if (cal.inc_dec) weekday_d = (weekday_q >= 3'd6) ? 3'd0 : weekday_q + 3'd1;
                     else             weekday_d = (weekday_q == 3'd0 || weekday_q > 3'd6) ? 3'd6 : weekday_q - 3'd1;
         endcase
      end

      dim_new = dim_of(month_d, year_d);
      if (((month_d != month_q) || (year_d != year_q)) && (day_d > dim_new))
         day_d = dim_new;
   end

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         day_q        <= 6'd1;
         month_q      <= 4'd1;
         year_q       <= '0;
         weekday_q    <= 3'(WEEKDAY_RST);
         done_day_q   <= 1'b0;
         done_month_q <= 1'b0;
         done_year_q  <= 1'b0;
      end else begin
         day_q        <= day_d;
         month_q      <= month_d;
         year_q       <= year_d;
         weekday_q    <= weekday_d;
         done_day_q   <= done_day_d;
         done_month_q <= done_month_d;
         done_year_q  <= done_year_d;
      end
   end

   assign cal.day        = day_q;
   assign cal.month      = month_q;
   assign cal.year       = year_q;
   assign cal.weekday    = weekday_q;
   assign cal.done_day   = done_day_q;
   assign cal.done_month = done_month_q;
   assign cal.done_year  = done_year_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench: stimulus pushes expected field snapshots stamped with the
// cycle they should appear on; a negedge monitor pops and compares them.
module tb_calendar_date_counter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Group 0 drives the default-parameter counter; group 1 drives both century-rule counters.
   logic       disp [2];
   logic [1:0] sel  [2];
   logic       tk   [2];
   logic       incd [2];
   logic       hr   [2];

   calendar_date_counter_if #(.YEAR_W(7)) ifa ();
   calendar_date_counter_if #(.YEAR_W(8)) ifg ();
   calendar_date_counter_if #(.YEAR_W(8)) ifl ();

   assign ifa.display = disp[0]; assign ifa.set_sel = sel[0]; assign ifa.tick = tk[0];
   assign ifa.inc_dec = incd[0]; assign ifa.done_hour = hr[0];
   assign ifg.display = disp[1]; assign ifg.set_sel = sel[1]; assign ifg.tick = tk[1];
   assign ifg.inc_dec = incd[1]; assign ifg.done_hour = hr[1];
   assign ifl.display = disp[1]; assign ifl.set_sel = sel[1]; assign ifl.tick = tk[1];
   assign ifl.inc_dec = incd[1]; assign ifl.done_hour = hr[1];

   calendar_date_counter u_a (.clk(clk), .rst(rst), .cal(ifa));
   calendar_date_counter #(.YEAR_W(8), .YEAR_MAX(199), .LEAP_MODE(1)) u_g (.clk(clk), .rst(rst), .cal(ifg));
   calendar_date_counter #(.YEAR_W(8), .YEAR_MAX(199), .LEAP_MODE(0)) u_l (.clk(clk), .rst(rst), .cal(ifl));

   typedef struct {
      int    id;
      string nm;
      int    stamp;
      int    d, m, y, w, dd, dm, dy;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int id, input string nm, input int d, input int m, input int y,
                       input int w, input int dd, input int dm, input int dy);
      exp_t e;
      e.id = id; e.nm = nm; e.stamp = cyc + 1;
      e.d = d; e.m = m; e.y = y; e.w = w; e.dd = dd; e.dm = dm; e.dy = dy;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int g = 0; g < 2; g++) begin tk[g] = 1'b0; hr[g] = 1'b0; end
   endtask

   task automatic ticks(input int g, input int s, input bit inc, input int n);
      for (int i = 0; i < n; i++) begin
         sel[g] = 2'(s); incd[g] = inc; tk[g] = 1'b1;
         step();
      end
   endtask

   // Monitor: every entry due on this cycle is compared against the matching counter.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            exp_t e;
            int ad, am, ay, aw, add, adm, ady;
            e = sb.pop_front();
            case (e.id)
               0: begin ad = ifa.day; am = ifa.month; ay = ifa.year; aw = ifa.weekday;
                        add = ifa.done_day; adm = ifa.done_month; ady = ifa.done_year; end
               1: begin ad = ifg.day; am = ifg.month; ay = ifg.year; aw = ifg.weekday;
                        add = ifg.done_day; adm = ifg.done_month; ady = ifg.done_year; end
               default: begin ad = ifl.day; am = ifl.month; ay = ifl.year; aw = ifl.weekday;
                        add = ifl.done_day; adm = ifl.done_month; ady = ifl.done_year; end
            endcase
            checks++;
            if (e.stamp != cyc || ad != e.d || am != e.m || ay != e.y || aw != e.w ||
                add != e.dd || adm != e.dm || ady != e.dy) begin
               errors++;
               $display("FAIL %s dut%0d cyc%0d: got d=%0d m=%0d y=%0d w=%0d carries=%0d%0d%0d, want d=%0d m=%0d y=%0d w=%0d carries=%0d%0d%0d (due cyc%0d)",
                        e.nm, e.id, cyc, ad, am, ay, aw, add, adm, ady,
                        e.d, e.m, e.y, e.w, e.dd, e.dm, e.dy, e.stamp);
            end
         end
      end
   end

   initial begin
      for (int g = 0; g < 2; g++) begin
         disp[g] = 1'b0; sel[g] = 2'b00; tk[g] = 1'b0; incd[g] = 1'b0; hr[g] = 1'b0;
      end
      #1;
      rst = 1'b1; @(posedge clk); #1;
      rst = 1'b1;
      push(0, "reset", 1, 1, 0, 6, 0, 0, 0);
      push(1, "reset_g", 1, 1, 0, 6, 0, 0, 0);
      push(2, "reset_l", 1, 1, 0, 6, 0, 0, 0);
      step();

      // Leap February in 2000, then rollover into March.
      disp[0] = 1'b1;
      ticks(0, 1, 1, 1);
      ticks(0, 0, 1, 27);
      push(0, "set_feb28", 28, 2, 0, 6, 0, 0, 0); step();
      disp[0] = 1'b0; hr[0] = 1'b1;
      push(0, "leap_feb29", 29, 2, 0, 0, 0, 0, 0); step();
      hr[0] = 1'b1;
      push(0, "leap_mar1", 1, 3, 0, 1, 1, 0, 0); step();
      push(0, "pulse_clear", 1, 3, 0, 1, 0, 0, 0); step();

      // Clamp on month change, non-leap then leap year.
      disp[0] = 1'b1;
      ticks(0, 1, 0, 2);
      ticks(0, 2, 1, 1);
      ticks(0, 0, 1, 30);
      push(0, "jan31_y1", 31, 1, 1, 1, 0, 0, 0); step();
      ticks(0, 1, 1, 1);
      push(0, "clamp_feb28", 28, 2, 1, 1, 0, 0, 0); step();
      ticks(0, 2, 1, 3);
      ticks(0, 1, 0, 1);
      ticks(0, 0, 1, 3);
      push(0, "jan31_y4", 31, 1, 4, 1, 0, 0, 0); step();
      ticks(0, 1, 1, 1);
      push(0, "clamp_feb29", 29, 2, 4, 1, 0, 0, 0); step();
      ticks(0, 1, 1, 2);
      ticks(0, 0, 1, 2);
      push(0, "day_inc_wrap", 1, 4, 4, 1, 0, 0, 0); step();
      ticks(0, 0, 0, 1);
      push(0, "day_dec_wrap", 30, 4, 4, 1, 0, 0, 0); step();
      ticks(0, 3, 0, 1);
      push(0, "wd_dec", 30, 4, 4, 0, 0, 0, 0); step();
      ticks(0, 3, 0, 1);
      push(0, "wd_wrap", 30, 4, 4, 6, 0, 0, 0); step();
      ticks(0, 1, 0, 4);
      push(0, "month_dec_clamp", 29, 12, 4, 6, 0, 0, 0); step();
      ticks(0, 0, 1, 2);
      ticks(0, 2, 0, 5);
      push(0, "dec31_y99", 31, 12, 99, 6, 0, 0, 0); step();

      // Hour carries are dropped in set mode.
      hr[0] = 1'b1;
      push(0, "set_iso_a", 31, 12, 99, 6, 0, 0, 0); step();
      hr[0] = 1'b1;
      push(0, "set_iso_b", 31, 12, 99, 6, 0, 0, 0); step();

      // Century wrap: all three carries for exactly one cycle.
      disp[0] = 1'b0; hr[0] = 1'b1;
      push(0, "century_wrap", 1, 1, 0, 0, 1, 1, 1); step();
      push(0, "century_clear", 1, 1, 0, 0, 0, 0, 0); step();

      // Back to Dec 31 y99; tick ignored in run mode; carry dropped on display rising edge.
      disp[0] = 1'b1;
      ticks(0, 1, 0, 1);
      ticks(0, 0, 0, 1);
      ticks(0, 2, 0, 1);
      disp[0] = 1'b0; sel[0] = 2'b00; incd[0] = 1'b1; tk[0] = 1'b1;
      push(0, "run_tick_ign", 31, 12, 99, 0, 0, 0, 0); step();
      disp[0] = 1'b1; hr[0] = 1'b1;
      push(0, "rise_drop", 31, 12, 99, 0, 0, 0, 0); step();

      // Reset coincident with a century carry.
      disp[0] = 1'b0; hr[0] = 1'b1; rst = 1'b1;
      push(0, "rst_mid", 1, 1, 0, 6, 0, 0, 0);
      push(1, "rst_mid_g", 1, 1, 0, 6, 0, 0, 0);
      push(2, "rst_mid_l", 1, 1, 0, 6, 0, 0, 0);
      step();
      push(0, "rst_hold", 1, 1, 0, 6, 0, 0, 0); step();

      // Century leap rule: 2100 is common under Gregorian, leap under the simple rule.
      disp[1] = 1'b1;
      ticks(1, 2, 1, 100);
      ticks(1, 1, 1, 1);
      ticks(1, 0, 1, 27);
      push(1, "b_feb28_g", 28, 2, 100, 6, 0, 0, 0);
      push(2, "b_feb28_l", 28, 2, 100, 6, 0, 0, 0);
      step();
      disp[1] = 1'b0; hr[1] = 1'b1;
      push(1, "greg_2100", 1, 3, 100, 0, 1, 0, 0);
      push(2, "simple_2100", 29, 2, 100, 0, 0, 0, 0);
      step();

      // Year decrement through 0 wraps to YEAR_MAX; clamp follows leap status on the way.
      disp[1] = 1'b1;
      ticks(1, 2, 0, 101);
      push(1, "ywrap_g", 1, 3, 199, 0, 0, 0, 0);
      push(2, "ywrap_l", 28, 2, 199, 0, 0, 0, 0);
      step();

      for (int i = 0; i < 50 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
